// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port synchronous RAM.
// One transaction at a time; RAM strobes are registered, read data returns to its issuer.
module ram_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data_in,
   output logic              ram_we,
   output logic              ram_re,
   input  logic [DATA_W-1:0] ram_data_out
);

   localparam int CNT_W = $clog2(RD_LAT + 1);

   typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, RESP} state_t;

   state_t            state, state_nxt;
   logic              last_grant;
   logic              owner;
   logic              grant;
   logic              hs;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] rsp_data;

   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid)
         grant = ~last_grant;
      else if (req1_valid)
         grant = 1'b1;

      // ready is gated by rst_n so it reads 0 while reset is held
      hs = rst_n && (state == IDLE) && (req0_valid || req1_valid);
      req0_ready = hs && !grant;
      req1_ready = hs && grant;

      sel_we    = grant ? req1_we    : req0_we;
      sel_addr  = grant ? req1_addr  : req0_addr;
      sel_wdata = grant ? req1_wdata : req0_wdata;

      state_nxt = state;
      case (state)
         IDLE:    if (hs) state_nxt = sel_we ? WR : RD;
         WR:      state_nxt = IDLE;
         RD:      state_nxt = RD_WAIT;
         RD_WAIT: if (cnt == CNT_W'(1)) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         owner       <= 1'b0;
         cnt         <= '0;
         rsp_data    <= '0;
         ram_addr    <= '0;
         ram_data_in <= '0;
         ram_we      <= 1'b0;
         ram_re      <= 1'b0;
      end else begin
         state  <= state_nxt;
         ram_we <= (state_nxt == WR);
         ram_re <= (state_nxt == RD);
         if (hs) begin
            last_grant  <= grant;
            owner       <= grant;
            ram_addr    <= sel_addr;
            ram_data_in <= sel_wdata;
         end
         if (state == RD)
            cnt <= CNT_W'(RD_LAT);
         else if (state == RD_WAIT)
            cnt <= cnt - CNT_W'(1);
         if (state == RD_WAIT && cnt == CNT_W'(1))
            rsp_data <= ram_data_out;
      end
   end

   assign rsp0_valid = (state == RESP) && !owner;
   assign rsp1_valid = (state == RESP) && owner;
   assign rsp0_rdata = rsp_data;
   assign rsp1_rdata = rsp_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: transaction-level model predicts grants, RAM ops and
// responses with cycle stamps; a monitor compares them whenever the DUT presents them.
module tb_ram_arbiter;

   localparam int RL = 1;

   typedef struct {
      logic       we;
      logic [3:0] addr;
      logic [7:0] data;
   } req_t;

   typedef struct {
      int unsigned cyc;
      logic        we;
      logic        re;
      logic [3:0]  addr;
      logic [7:0]  data;
   } op_t;

   typedef struct {
      int unsigned cyc;
      int          port;
      logic [7:0]  data;
   } rsp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req0_we, req0_ready, rsp0_valid;
   logic [3:0] req0_addr;
   logic [7:0] req0_wdata, rsp0_rdata;
   logic       req1_valid, req1_we, req1_ready, rsp1_valid;
   logic [3:0] req1_addr;
   logic [7:0] req1_wdata, rsp1_rdata;
   logic [3:0] ram_addr;
   logic [7:0] ram_data_in, ram_data_out;
   logic       ram_we, ram_re;

   logic       mem_init;
   logic [7:0] mem      [16];
   logic [7:0] init_val [16];
   logic [7:0] ref_mem  [16];

   req_t pq0[$], pq1[$];
   op_t  opq[$];
   rsp_t rq[$];

   int unsigned cyc = 0;
   int unsigned free_cyc = 0;
   int          last_grant = 1;
   int          n_cmp = 0;
   int          n_bad = 0;

   ram_arbiter #(.ADDR_W(4), .DATA_W(8), .RD_LAT(RL)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .ram_addr(ram_addr), .ram_data_in(ram_data_in),
      .ram_we(ram_we), .ram_re(ram_re), .ram_data_out(ram_data_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // single-port RAM with one cycle read latency
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_val[i];
      end else if (ram_we) begin
         mem[ram_addr] <= ram_data_in;
      end
      if (ram_re) ram_data_out <= mem[ram_addr];
   end

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void fail_now(string name, string what);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
   endfunction

   task automatic push(input int p, input logic we, input logic [3:0] a, input logic [7:0] d);
      req_t r;
      r.we = we;
      r.addr = a;
      r.data = d;
      if (p == 0) pq0.push_back(r);
      else pq1.push_back(r);
   endtask

   task automatic wait_idle(input int unsigned budget);
      int unsigned n = 0;
      while ((pq0.size() != 0 || pq1.size() != 0 || rq.size() != 0 || opq.size() != 0 ||
              cyc < free_cyc) && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (n >= budget) begin
         fail_now("idle_timeout", "transactions still outstanding after cycle budget");
         pq0.delete();
         pq1.delete();
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req0_ready"}, 32'(req0_ready), 0);
      check({tag, "_req1_ready"}, 32'(req1_ready), 0);
      check({tag, "_rsp0_valid"}, 32'(rsp0_valid), 0);
      check({tag, "_rsp1_valid"}, 32'(rsp1_valid), 0);
      check({tag, "_rsp0_rdata"}, 32'(rsp0_rdata), 0);
      check({tag, "_rsp1_rdata"}, 32'(rsp1_rdata), 0);
      check({tag, "_ram_addr"}, 32'(ram_addr), 0);
      check({tag, "_ram_data_in"}, 32'(ram_data_in), 0);
      check({tag, "_ram_we"}, 32'(ram_we), 0);
      check({tag, "_ram_re"}, 32'(ram_re), 0);
   endtask

   // Driver plus reference model: present queue heads, predict the grant, record expectations.
   initial begin
      req_t r;
      op_t  o;
      rsp_t s;
      int   g;
      req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
      forever begin
         @(negedge clk);
         req0_valid = (pq0.size() != 0);
         if (pq0.size() != 0) begin
            req0_we = pq0[0].we; req0_addr = pq0[0].addr; req0_wdata = pq0[0].data;
         end
         req1_valid = (pq1.size() != 0);
         if (pq1.size() != 0) begin
            req1_we = pq1[0].we; req1_addr = pq1[0].addr; req1_wdata = pq1[0].data;
         end
         #1;
         g = -1;
         if (!rst_n) begin
            rq.delete();
            opq.delete();
            last_grant = 1;
            free_cyc = 0;
         end else if (cyc >= free_cyc) begin
            if (req0_valid && req1_valid) g = 1 - last_grant;
            else if (req0_valid) g = 0;
            else if (req1_valid) g = 1;
         end
         if (req0_valid || req1_valid) begin
            check("req0_ready", 32'(req0_ready), 32'(g == 0));
            check("req1_ready", 32'(req1_ready), 32'(g == 1));
         end
         if (g >= 0) begin
            r = (g == 0) ? pq0.pop_front() : pq1.pop_front();
            last_grant = g;
            o.cyc = cyc + 1;
            o.we = r.we;
            o.re = !r.we;
            o.addr = r.addr;
            o.data = r.data;
            opq.push_back(o);
            if (r.we) begin
               ref_mem[r.addr] = r.data;
               free_cyc = cyc + 2;
            end else begin
               s.cyc = cyc + 2 + RL;
               s.port = g;
               s.data = ref_mem[r.addr];
               rq.push_back(s);
               free_cyc = cyc + 3 + RL;
            end
         end
      end
   end

   // Monitor: pop and compare whenever the DUT presents a RAM op or a response.
   initial begin
      op_t  o;
      rsp_t s;
      forever begin
         @(negedge clk);
         #2;
         if (ram_we && ram_re) fail_now("we_re_both", "ram_we=1 and ram_re=1, required never both");
         if (ram_we || ram_re) begin
            if (opq.size() == 0) begin
               fail_now("ram_op_unexpected", $sformatf("ram_we=%0b ram_re=%0b, required none", ram_we, ram_re));
            end else begin
               o = opq.pop_front();
               check("op_cycle", cyc, o.cyc);
               check("ram_we", 32'(ram_we), 32'(o.we));
               check("ram_re", 32'(ram_re), 32'(o.re));
               check("ram_addr", 32'(ram_addr), 32'(o.addr));
               if (o.we) check("ram_data_in", 32'(ram_data_in), 32'(o.data));
            end
         end else if (opq.size() != 0 && opq[0].cyc < cyc) begin
            fail_now("ram_op_missing", $sformatf("no strobe, required one at cycle %0d", opq[0].cyc));
            void'(opq.pop_front());
         end
         if (rsp0_valid || rsp1_valid) begin
            if (rq.size() == 0) begin
               fail_now("rsp_unexpected", $sformatf("rsp0_valid=%0b rsp1_valid=%0b, required none", rsp0_valid, rsp1_valid));
            end else begin
               s = rq.pop_front();
               check("rsp_cycle", cyc, s.cyc);
               check("rsp0_valid", 32'(rsp0_valid), 32'(s.port == 0));
               check("rsp1_valid", 32'(rsp1_valid), 32'(s.port == 1));
               check("rsp_rdata", 32'((s.port == 1) ? rsp1_rdata : rsp0_rdata), 32'(s.data));
            end
         end else if (rq.size() != 0 && rq[0].cyc < cyc) begin
            fail_now("rsp_missing", $sformatf("no response, required one at cycle %0d", rq[0].cyc));
            void'(rq.pop_front());
         end
      end
   end

   initial begin
      #1000000;
      fail_now("watchdog", "simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned due;
      int unsigned n;
      for (int i = 0; i < 16; i++) begin
         init_val[i] = 8'($urandom);
         ref_mem[i] = init_val[i];
      end
      rst_n = 1'b0;
      mem_init = 1'b1;

      // reset held with both valids high
      push(0, 1'b0, 4'd7, 8'h00);
      push(1, 1'b0, 4'd9, 8'h00);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2;
      check_all_zero("reset");
      mem_init = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      wait_idle(50);

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #2;
         check("idle_ram_we", 32'(ram_we), 0);
         check("idle_ram_re", 32'(ram_re), 0);
      end

      // port 0 write then read
      push(0, 1'b1, 4'd2, 8'hAB);
      push(0, 1'b0, 4'd2, 8'h00);
      wait_idle(50);

      // simultaneous requests straight after reset
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      push(0, 1'b1, 4'd4, 8'hCD);
      push(1, 1'b0, 4'd4, 8'h00);
      wait_idle(50);

      // fairness under contention
      for (int i = 0; i < 3; i++) begin
         push(0, 1'b0, 4'd1, 8'h00);
         push(1, 1'b0, 4'd3, 8'h00);
      end
      wait_idle(100);

      // reset during RD_WAIT
      push(1, 1'b0, 4'd5, 8'h00);
      n = 0;
      while (rq.size() == 0 && n < 20) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (rq.size() == 0) begin
         fail_now("midread_grant", "read never granted");
      end else begin
         due = rq[0].cyc;
         n = 0;
         while (cyc < due - 1 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
         end
         rst_n = 1'b0;
         #1;
         check("midread_ram_we", 32'(ram_we), 0);
         check("midread_ram_re", 32'(ram_re), 0);
         repeat (2) @(negedge clk);
         #2;
         check_all_zero("midread");
         @(posedge clk);
         #2;
         rst_n = 1'b1;
      end
      push(1, 1'b0, 4'd2, 8'h00);
      wait_idle(50);

      // boundary address
      push(1, 1'b1, 4'd15, 8'hFF);
      push(1, 1'b0, 4'd15, 8'h00);
      wait_idle(50);
      push(0, 1'b0, 4'd0, 8'h00);
      wait_idle(50);

      // random bursts
      for (int b = 0; b < 10; b++) begin
         n = $urandom_range(1, 8);
         for (int i = 0; i < int'(n); i++)
            push(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom));
         wait_idle(n * 12 + 20);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
